// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: one operation per accepted bundle, one-deep output
// register with zero/parity flags and a wrapping count of accepted bundles.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  // Handshake: a bundle transfers on any edge where in_valid && in_ready; a result
  // leaves on any edge where out_valid && out_ready. in_ready never looks at in_valid,
  // so a full register still takes a new bundle in the same cycle it drains.
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] f;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_comb begin
    f = '0;
    case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = ~a;
      3'd3: f = ~(a & b);
      3'd4: f = ~(a | b);
      3'd5: f = a ^ b;
      3'd6: f = ~(a ^ b);
      3'd7: f = b;
      default: f = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        y        <= f;
        zero     <= (f == '0);
        parity   <= ^f;
        op_count <= op_count + CNT_W'(1);
      end
      // Result data is left untouched on a plain drain; only the valid flag drops.
      if (accept) begin
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
